note_uart_tx: RTL and testbench

Transmit-side UART block for the piano: watches the 10-bit note/pitch bus driven to the buzzer and turns every change into a one-byte event. Events are buffered in a small FIFO and serialized 8N1 on `uart_txd`, so the host sees what is being played in any mode. It is the outbound counterpart of the existing UART note receiver and sits in the top level beside it, fed from the same note bus as the buzzer, LEDs and display.

---
 rtl/note_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_note_uart_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_uart_tx.sv
// note_uart_tx: turns every change on the one-hot note bus into a byte event,
// buffers events in a small FIFO and sends them 8N1 on uart_txd.
module note_uart_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] note,
  input  logic       enable,
  output logic       uart_txd,
  output logic       busy,
  output logic       overflow
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CPB_M1 = CW'(CPB - 1);
  localparam logic [AW:0]   FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [9:0]    note_q;
  logic [7:0]    last_byte;
  logic [7:0]    enc;
  logic [2:0]    idx;
  logic [1:0]    pitch;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [AW:0]   cnt_n;

  logic          push;
  logic          pop;
  logic          full;
  logic          accept;

  state_t        state;
  logic [CW-1:0] baud;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          bit_end;

  // lowest note bit wins for idx, highest octave bit wins for pitch
  always_comb begin
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (note_q[i]) idx = 3'(i + 1);
    end
    if (note_q[9])      pitch = 2'b11;
    else if (note_q[8]) pitch = 2'b10;
    else if (note_q[7]) pitch = 2'b01;
    else                pitch = 2'b00;
    if (idx == 3'd0) enc = 8'h00;
    else             enc = {1'b1, pitch, 2'b00, idx};
  end

  assign bit_end = (baud == CPB_M1);
  assign push    = enable && (enc != last_byte);
  assign full    = (count == FULL);
  // a frame may start from IDLE or straight out of the last stop-bit cycle
  assign pop     = (count != '0) &&
                   ((state == IDLE) || ((state == STOP) && bit_end));
  assign accept  = push && (!full || pop);

  always_comb begin
    cnt_n = count;
    if (accept && !pop)      cnt_n = count + 1'b1;
    else if (!accept && pop) cnt_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_q    <= '0;
      last_byte <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      note_q <= note;
      count  <= cnt_n;
      if (push) last_byte <= enc;
      if (push && !accept) overflow <= 1'b1;
      if (accept) begin
        mem[tail] <= enc;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bitn     <= '0;
      shreg    <= '0;
      uart_txd <= 1'b1;
      busy     <= 1'b0;
    end else begin
      busy <= (cnt_n != '0) || (state != IDLE) || pop;
      unique case (state)
        IDLE: begin
          uart_txd <= 1'b1;
          if (pop) begin
            shreg <= mem[head];
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          uart_txd <= 1'b0;
          if (bit_end) begin
            baud  <= '0;
            bitn  <= '0;
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          uart_txd <= shreg[0];
          if (bit_end) begin
            baud  <= '0;
            shreg <= shreg >> 1;
            if (bitn == 3'd7) state <= STOP;
            else              bitn  <= bitn + 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          uart_txd <= 1'b1;
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shreg <= mem[head];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_uart_tx.sv
// Bench for note_uart_tx: random note changes against a byte-level event model,
// with a line decoder recovering frames from uart_txd.
module tb_note_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] note;
  logic       enable;
  logic       uart_txd;
  logic       busy;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  time        starts[$];
  logic [7:0] mlast;

  note_uart_tx #(
    .CLK_HZ(16),
    .BAUD(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .note(note),
    .enable(enable),
    .uart_txd(uart_txd),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [7:0] encode(input logic [9:0] n);
    int idx;
    int p;
    idx = 0;
    p   = 0;
    for (int i = 6; i >= 0; i--) if (n[i]) idx = i + 1;
    if (n[9])      p = 3;
    else if (n[8]) p = 2;
    else if (n[7]) p = 1;
    if (idx == 0) return 8'h00;
    return 8'(128 + p * 32 + idx);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  // keep=0 models an event the design must drop
  task automatic drive(input logic [9:0] n, input logic en, input bit keep);
    logic [7:0] b;
    @(posedge clk);
    #1;
    note   = n;
    enable = en;
    b = encode(n);
    if (en && b != mlast) begin
      if (keep) exp_q.push_back(b);
      mlast = b;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    tick(4);
    while (busy !== 1'b0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) chk("idle_timeout", 1, 0);
    tick(20);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    chk({tag, "_nframes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_frame%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    starts.delete();
  endtask

  // line decoder: samples mid-bit, abandons a frame cut by reset
  initial begin
    logic [7:0] b;
    logic       st;
    logic       sp;
    bit         ab;
    time        t0;
    forever begin
      @(negedge uart_txd);
      if (rst !== 1'b0) continue;
      t0 = $time;
      ab = 0;
      b  = '0;
      st = 1'b1;
      sp = 1'b0;
      for (int k = 0; k < 152 && !ab; k++) begin
        @(negedge clk);
        if (rst !== 1'b0) ab = 1;
        else if (k == 7) st = uart_txd;
        else if (k >= 23 && k <= 135 && (k - 23) % 16 == 0)
          b[(k - 23) / 16] = uart_txd;
        else if (k == 151) sp = uart_txd;
      end
      if (!ab) begin
        chk("start_bit", st, 0);
        chk("stop_bit", sp, 1);
        starts.push_back(t0);
        got_q.push_back(b);
      end
    end
  end

  initial begin
    int lat;
    int k;
    logic [9:0] ov_notes [7];
    ov_notes = '{10'h001, 10'h002, 10'h004, 10'h008,
                 10'h010, 10'h020, 10'h040};

    // reset with a note held
    rst    = 1'b1;
    note   = 10'h001;
    enable = 1'b1;
    mlast  = 8'h00;
    tick(3);
    @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(encode(10'h001));
    mlast = encode(10'h001);
    chk("held_code", encode(10'h001), 8'h81);
    wait_idle();
    compare_frames("reset");

    // press/release with start-bit latency
    drive(10'h104, 1'b1, 1'b1);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (uart_txd === 1'b0) break;
    end
    chk("latency", lat, 4);
    chk("busy_in_frame", busy, 1);
    tick(200 - lat);
    drive(10'h000, 1'b1, 1'b1);
    wait_idle();
    chk("press_code", exp_q.size() > 0 ? exp_q[0] : 8'hxx, 8'hC3);
    compare_frames("press");

    // octave priority
    drive(10'h2C0, 1'b1, 1'b1);
    wait_idle();
    chk("prio_code", exp_q.size() > 0 ? exp_q[0] : 8'hxx, 8'hE7);
    compare_frames("prio");

    // random changes spaced beyond one frame
    for (int i = 0; i < 10; i++) begin
      logic [9:0] n;
      n = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) n[6:0] = '0;
      drive(n, 1'b1, 1'b1);
      tick($urandom_range(170, 300));
    end
    wait_idle();
    compare_frames("rand");

    // burst: shifter plus four FIFO entries survive
    drive(10'h000, 1'b1, 1'b1);
    wait_idle();
    compare_frames("pre_ovf");
    chk("ovf_clear", overflow, 0);
    for (int i = 0; i < 7; i++) begin
      drive(ov_notes[i], 1'b1, i < 5);
      tick(1);
    end
    tick(4);
    chk("ovf_set", overflow, 1);
    wait_idle();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_idle_busy", busy, 0);
    if (starts.size() >= 2)
      chk("b2b_spacing", 32'(starts[1] - starts[0]), 32'(CPB * 10 * 10));
    else
      chk("b2b_spacing", 0, 32'(CPB * 10 * 10));
    compare_frames("ovf");

    // enable gating
    drive(10'h000, 1'b1, 1'b1);
    wait_idle();
    compare_frames("pre_en");
    drive(10'h001, 1'b0, 1'b1);
    tick(10);
    drive(10'h002, 1'b0, 1'b1);
    tick(10);
    drive(10'h001, 1'b0, 1'b1);
    tick(200);
    chk("disabled_frames", got_q.size(), 0);
    drive(10'h001, 1'b1, 1'b1);
    wait_idle();
    compare_frames("enable");

    // reset in the middle of data bit 3
    drive(10'h008, 1'b1, 1'b0);
    k = 0;
    while (uart_txd !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("mid_start_timeout", 1, 0);
    repeat (16 * 4 + 8) @(negedge clk);
    chk("mid_in_frame", busy, 1);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    note = 10'h000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_txd_high", uart_txd, 1);
    chk("mid_busy", busy, 0);
    chk("mid_ovf_cleared", overflow, 0);
    mlast = 8'h00;
    tick(400);
    chk("mid_no_frames", got_q.size(), 0);
    drive(10'h010, 1'b1, 1'b1);
    wait_idle();
    compare_frames("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
